// File: rtl/display_scanner.sv
// Time-multiplexed scanner for common-anode seven-segment digits: double-buffered value,
// one digit per DIV-cycle dwell, active-low one-hot digit enable, optional leading-zero blanking.
module display_scanner #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic                  load_i,
  input  logic                  blank_lz_i,
  output logic [3:0]            nibble_o,
  output logic [DIGITS-1:0]     digit_en_o,
  output logic                  blank_o,
  output logic                  pending_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] shd_q, shd_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic                pending_q, pending_d;
  logic                lz_q;

  logic                tick;
  logic                wrap;
  logic [DIGITS-1:0]   hi_zero;

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shd_q     <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      lz_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shd_q     <= shd_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      lz_q      <= blank_lz_i;
    end
  end

  // Prescaler and digit index
  always_comb begin
    tick  = (cnt_q == CntMax);
    wrap  = tick && (idx_q == IdxMax);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
  end

  // Apply is evaluated before load so a load in the wrap cycle keeps pending set
  // and leaves the freshly captured value for the following frame.
  always_comb begin
    shd_d     = shd_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (wrap && pending_q) begin
      disp_d    = shd_q;
      pending_d = 1'b0;
    end
    if (load_i) begin
      shd_d     = value_i;
      pending_d = 1'b1;
    end
  end

  // hi_zero[k]: nibbles k..DIGITS-1 of the displayed value are all zero
  always_comb begin
    hi_zero = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      hi_zero[k] = ((disp_q >> (4 * k)) == '0);
    end
  end

  always_comb begin
    nibble_o   = '0;
    digit_en_o = '1;
    blank_o    = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == IdxW'(k)) begin
        nibble_o      = disp_q[4*k +: 4];
        digit_en_o[k] = 1'b0;
        blank_o       = lz_q && (k != 0) && hi_zero[k];
      end
    end
  end

  assign pending_o = pending_q;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: a time-based reference model predicts every cycle's
// outputs; a negedge monitor pops and compares them.
module tb_display_scanner;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DIV    = 3;
  localparam int unsigned FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  nibble;
  logic [3:0]  digit_en;
  logic        blank;
  logic        pending;

  display_scanner #(
    .DIGITS(DIGITS),
    .DIV   (DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value_i   (value),
    .load_i    (load),
    .blank_lz_i(blank_lz),
    .nibble_o  (nibble),
    .digit_en_o(digit_en),
    .blank_o   (blank),
    .pending_o (pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] nib;
    logic [3:0] en;
    logic       blank;
    logic       pend;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: time since reset plus the architectural registers
  int          t = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_shd = '0;
  bit          m_pend = 0;
  bit          m_lz = 0;
  bit          cur_lz = 0;

  function automatic exp_t predict();
    exp_t        e;
    int          idx;
    logic [15:0] upper;
    logic [3:0]  one;
    idx     = (t / DIV) % DIGITS;
    upper   = m_disp >> (4 * idx);
    one     = 4'b0001;
    e.nib   = upper[3:0];
    e.en    = ~(one << idx);
    e.blank = m_lz && (idx > 0) && (upper == 16'h0);
    e.pend  = m_pend;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
    end
  endtask

  // Monitor: compares whatever the model predicted for this sample point
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("nibble", int'(nibble), int'(e.nib));
      check("digit_en", int'(digit_en), int'(e.en));
      check("blank", int'(blank), int'(e.blank));
      check("pending", int'(pending), int'(e.pend));
    end
  end

  // One cycle: drive inputs after a negedge, advance the model across the coming posedge.
  task automatic step(input bit rn, input bit ld, input logic [15:0] v, input bit lz);
    @(negedge clk);
    #2;
    rst_n    = rn;
    load     = ld;
    value    = v;
    blank_lz = lz;
    cur_lz   = lz;
    if (!rn) begin
      t = 0; m_disp = '0; m_shd = '0; m_pend = 0; m_lz = 0;
    end else begin
      if ((t % FRAME) == FRAME - 1 && m_pend) begin
        m_disp = m_shd;
        m_pend = 0;
      end
      if (ld) begin
        m_shd  = v;
        m_pend = 1;
      end
      m_lz = lz;
      t++;
    end
    q.push_back(predict());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, value, cur_lz);
  endtask

  task automatic do_load(input logic [15:0] v);
    step(1, 1, v, cur_lz);
  endtask

  task automatic align(input int r);
    for (int i = 0; i < FRAME && (t % FRAME) != r; i++) step(1, 0, value, cur_lz);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] masks [5];
    masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

    // Reset held, then free-run through more than one frame
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0);
    idle(14);

    // Load while digit 1 is active; applied at next wrap
    align(4);
    do_load(16'h1A2F);
    idle(26);

    // Two loads in one frame: the later one wins
    align(1);
    do_load(16'h1111);
    idle(3);
    do_load(16'h2222);
    idle(26);

    // Leading-zero blanking
    step(1, 0, value, 1);
    do_load(16'h0000);
    idle(26);
    do_load(16'h0300);
    idle(26);
    step(1, 0, value, 0);

    // Load in the wrap cycle while a value is already pending
    align(3);
    do_load(16'h5678);
    align(FRAME - 1);
    do_load(16'h9ABC);
    idle(30);

    // Reset mid-frame with a pending load
    align(6);
    do_load(16'h4321);
    idle(1);
    step(0, 0, value, cur_lz);
    step(0, 0, value, cur_lz);
    idle(20);

    // Randomised traffic, biased toward values with leading zeros
    for (int i = 0; i < 1500; i++) begin
      bit          rn;
      bit          ld;
      bit          lz;
      logic [15:0] v;
      rn = ($urandom_range(0, 199) != 0);
      ld = ($urandom_range(0, 7) == 0);
      lz = ($urandom_range(0, 15) == 0) ? ~cur_lz : cur_lz;
      v  = 16'($urandom) & masks[$urandom_range(0, 4)];
      step(rn, ld, v, lz);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
